// File: rtl/polaris_pkg.sv
// Shared definitions for the Polaris instruction-fetch unit: bus constants,
// the fetch FSM state type and the instruction-queue entry layout.
package polaris_pkg;

    localparam logic [1:0]  SIZE_WORD            = 2'd2;
    localparam logic [1:0]  RVC_LOW              = 2'b11;
    localparam logic [63:0] DEFAULT_RESET_VECTOR = 64'hFFFF_FFFF_FFFF_FF00;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_ADDR = 2'd1,
        FETCH_DATA = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic        fault;
        logic [63:0] pc;
        logic [31:0] insn;
    } fetch_entry_t;

endpackage

// File: rtl/polaris_ifetch_fifo.sv
// Instruction queue for polaris_ifetch: DEPTH entries of {fault, pc, insn},
// up to two pushes and one pop per cycle, synchronous flush (a push in the
// flush cycle lands in the emptied queue), and a free-slot count.
module polaris_ifetch_fifo
    import polaris_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_flush,
    input  logic [1:0]                 i_push_n,
    input  fetch_entry_t               i_push0,
    input  fetch_entry_t               i_push1,
    input  logic                       i_pop,
    output fetch_entry_t               o_head,
    output logic                       o_valid,
    output logic [$clog2(DEPTH):0]     o_free
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    fetch_entry_t  r_mem [DEPTH];
    logic [PW-1:0] r_rd;
    logic [PW-1:0] r_wr;
    logic [CW-1:0] r_cnt;
    logic [PW-1:0] w_wa0;
    logic [PW-1:0] w_wa1;
    logic          w_pop;

    assign w_pop   = i_pop && (r_cnt != '0);
    assign o_valid = (r_cnt != '0);
    assign o_head  = r_mem[r_rd];
    assign o_free  = CW'(DEPTH) - r_cnt;
    assign w_wa0   = i_flush ? '0 : r_wr;
    assign w_wa1   = w_wa0 + 1'b1;

    // Pointer and occupancy bookkeeping; flush restarts the queue at slot 0.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else if (i_flush) begin
            r_rd  <= '0;
            r_wr  <= PW'(i_push_n);
            r_cnt <= CW'(i_push_n);
        end else begin
            if (w_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            r_wr  <= r_wr + PW'(i_push_n);
            r_cnt <= r_cnt + CW'(i_push_n) - CW'(w_pop);
        end
    end

    // Entry storage; lower word always goes first so decode sees program order.
    always_ff @(posedge i_clk) begin
        if (i_push_n != 2'd0) begin
            r_mem[w_wa0] <= i_push0;
        end
        if (i_push_n == 2'd2) begin
            r_mem[w_wa1] <= i_push1;
        end
    end

endmodule

// File: rtl/polaris_ifetch.sv
// Polaris RV64 instruction fetch: issues BUS_W-bit program beats, assembles
// 32-bit instructions into a DEPTH-entry queue and restarts on redirect.
// Optional feature macro: POLARIS_IFETCH_MISALIGN_EN (misaligned redirect
// targets produce a single fault entry instead of a fetch).
module polaris_ifetch
    import polaris_pkg::*;
#(
    parameter int unsigned BUS_W        = 16,
    parameter int unsigned DEPTH        = 4,
    parameter logic [63:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [BUS_W-1:0] dat_i,
    input  logic             ack_i,
    output logic [63:0]      adr_o,
    output logic [1:0]       size_o,
    output logic             we_o,
    output logic             vpa_o,
    input  logic             redirect_i,
    input  logic [63:0]      redirect_pc_i,
    output logic [31:0]      insn_o,
    output logic [63:0]      insn_pc_o,
    output logic             insn_valid_o,
    input  logic             insn_ready_i,
    output logic             undefined_o,
    output logic             insn_fault_o
);

    localparam int unsigned BEAT_B = BUS_W / 8;
    localparam int unsigned IPB    = (BUS_W == 64) ? 2 : 1;
    localparam int unsigned CW     = $clog2(DEPTH) + 1;
    localparam logic [63:0] ALIGN  = ~(64'(BEAT_B) - 64'd1);

    fetch_state_e  r_state, w_state;
    logic [63:0]   r_adr, w_adr;
    logic          r_half, w_half;   // low halfword held, high half still due
    logic [15:0]   r_lo, w_lo;
    logic          r_drop, w_drop;   // discard low word of next 64-bit beat
    logic          r_halt, w_halt;   // parked on a misaligned-target fault
    logic [63:0]   w_dat;
    logic          w_ack, w_pop, w_mis, w_room, w_head_valid;
    logic [1:0]    w_push_n;
    fetch_entry_t  w_push0, w_push1, w_head;
    logic [CW-1:0] w_free;
    int            w_free_next;

    assign w_dat       = 64'(dat_i);
    assign w_ack       = (r_state == FETCH_DATA) && ack_i;
    assign w_pop       = w_head_valid && insn_ready_i;
    assign w_free_next = int'(w_free) + int'(w_pop) - int'(w_push_n);
    assign w_room      = (w_free_next >= int'(IPB));

`ifdef POLARIS_IFETCH_MISALIGN_EN
    assign w_mis        = (redirect_pc_i[1:0] != 2'b00);
    assign insn_fault_o = w_head_valid && w_head.fault;
`else
    assign w_mis        = 1'b0;
    assign insn_fault_o = 1'b0;
`endif

    // Queue writes: assembled words on ack, or the fault entry on a bad redirect.
    always_comb begin
        w_push_n = 2'd0;
        w_push0  = '0;
        w_push1  = '0;
        if (redirect_i) begin
            if (w_mis) begin
                w_push_n      = 2'd1;
                w_push0.fault = 1'b1;
                w_push0.pc    = redirect_pc_i;
            end
        end else if (w_ack) begin
            if (BUS_W == 16) begin
                w_push_n     = r_half ? 2'd1 : 2'd0;
                w_push0.pc   = r_adr - 64'd2;
                w_push0.insn = {w_dat[15:0], r_lo};
            end else if (BUS_W == 32) begin
                w_push_n     = 2'd1;
                w_push0.pc   = r_adr;
                w_push0.insn = w_dat[31:0];
            end else if (r_drop) begin
                w_push_n     = 2'd1;
                w_push0.pc   = r_adr + 64'd4;
                w_push0.insn = w_dat[63:32];
            end else begin
                w_push_n     = 2'd2;
                w_push0.pc   = r_adr;
                w_push0.insn = w_dat[31:0];
                w_push1.pc   = r_adr + 64'd4;
                w_push1.insn = w_dat[63:32];
            end
        end
    end

    // Bus FSM next state; redirect overrides everything in flight.
    always_comb begin
        w_state = r_state;
        w_adr   = r_adr;
        w_half  = r_half;
        w_lo    = r_lo;
        w_drop  = r_drop;
        w_halt  = r_halt;
        if (redirect_i) begin
            w_adr   = redirect_pc_i & ALIGN;
            w_half  = 1'b0;
            w_drop  = (BUS_W == 64) && redirect_pc_i[2];
            w_halt  = w_mis;
            w_state = w_mis ? FETCH_IDLE : FETCH_ADDR;
        end else begin
            unique case (r_state)
                FETCH_IDLE: begin
                    if (!r_halt && w_room) begin
                        w_state = FETCH_ADDR;
                    end
                end
                FETCH_ADDR: w_state = FETCH_DATA;
                FETCH_DATA: begin
                    if (ack_i) begin
                        w_adr   = r_adr + 64'(BEAT_B);
                        w_half  = (BUS_W == 16) && !r_half;
                        w_lo    = w_dat[15:0];
                        w_drop  = 1'b0;
                        w_state = w_room ? FETCH_ADDR : FETCH_IDLE;
                    end
                end
                default: w_state = FETCH_IDLE;
            endcase
        end
    end

    // Fetch state registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= FETCH_ADDR;
            r_adr   <= RESET_VECTOR & ALIGN;
            r_half  <= 1'b0;
            r_lo    <= 16'h0000;
            r_drop  <= (BUS_W == 64) && RESET_VECTOR[2];
            r_halt  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_adr   <= w_adr;
            r_half  <= w_half;
            r_lo    <= w_lo;
            r_drop  <= w_drop;
            r_halt  <= w_halt;
        end
    end

    polaris_ifetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk    (clk_i),
        .i_rst    (reset_i),
        .i_flush  (redirect_i),
        .i_push_n (w_push_n),
        .i_push0  (w_push0),
        .i_push1  (w_push1),
        .i_pop    (w_pop),
        .o_head   (w_head),
        .o_valid  (w_head_valid),
        .o_free   (w_free)
    );

    assign adr_o        = r_adr;
    assign vpa_o        = (r_state != FETCH_IDLE);
    assign size_o       = SIZE_WORD;
    assign we_o         = 1'b0;
    assign insn_o       = w_head.insn;
    assign insn_pc_o    = w_head.pc;
    assign insn_valid_o = w_head_valid;
    assign undefined_o  = w_head_valid && !w_head.fault && (w_head.insn[1:0] != RVC_LOW);

endmodule

// File: tb/tb_polaris_ifetch.sv
// Bench for polaris_ifetch: a 16-bit-bus and a 64-bit-bus instance (DEPTH=2)
// served by a halfword memory model; a program-order model checks every pop.
module tb_polaris_ifetch;

    localparam logic [63:0] RV = 64'hFFFF_FFFF_FFFF_FF00;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // 16-bit instance signals
    logic        rst16, ack16, redir16, ready16;
    logic [15:0] dat16;
    logic [63:0] rpc16, adr16, ipc16;
    logic [1:0]  size16;
    logic        we16, vpa16, valid16, undef16, fault16;
    logic [31:0] insn16;

    // 64-bit instance signals
    logic        rst64, ack64, redir64, ready64;
    logic [63:0] dat64;
    logic [63:0] rpc64, adr64, ipc64;
    logic [1:0]  size64;
    logic        we64, vpa64, valid64, undef64, fault64;
    logic [31:0] insn64;

    polaris_ifetch #(.BUS_W(16), .DEPTH(2)) u_dut16 (
        .clk_i(clk), .reset_i(rst16), .dat_i(dat16), .ack_i(ack16), .adr_o(adr16),
        .size_o(size16), .we_o(we16), .vpa_o(vpa16), .redirect_i(redir16),
        .redirect_pc_i(rpc16), .insn_o(insn16), .insn_pc_o(ipc16), .insn_valid_o(valid16),
        .insn_ready_i(ready16), .undefined_o(undef16), .insn_fault_o(fault16)
    );

    polaris_ifetch #(.BUS_W(64), .DEPTH(2)) u_dut64 (
        .clk_i(clk), .reset_i(rst64), .dat_i(dat64), .ack_i(ack64), .adr_o(adr64),
        .size_o(size64), .we_o(we64), .vpa_o(vpa64), .redirect_i(redir64),
        .redirect_pc_i(rpc64), .insn_o(insn64), .insn_pc_o(ipc64), .insn_valid_o(valid64),
        .insn_ready_i(ready64), .undefined_o(undef64), .insn_fault_o(fault64)
    );

    // Program memory, one halfword per even address.
    function automatic logic [15:0] mem_half(input logic [63:0] a);
        case (a)
            64'hFFFF_FFFF_FFFF_FF00: return 16'h0013;
            64'hFFFF_FFFF_FFFF_FF02: return 16'h0000;
            64'hFFFF_FFFF_FFFF_FF04: return 16'hFFFF;
            64'hFFFF_FFFF_FFFF_FF06: return 16'hFFFF;
            64'hFFFF_FFFF_FFFF_FF08: return 16'h0000;
            64'hFFFF_FFFF_FFFF_FF0A: return 16'h0000;
            default:                 return a[15:0] ^ 16'hA5C3;
        endcase
    endfunction

    function automatic logic [31:0] mem_word(input logic [63:0] pc);
        return {mem_half(pc + 64'd2), mem_half(pc)};
    endfunction

    always_comb dat16 = mem_half(adr16);
    always_comb dat64 = {mem_half(adr64 + 64'd6), mem_half(adr64 + 64'd4),
                         mem_half(adr64 + 64'd2), mem_half(adr64)};

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid16(input int budget);
        int n = 0;
        while (!valid16 && n < budget) begin
            tick();
            n++;
        end
        check("wait_valid16", valid16, 1);
    endtask

    // Program-order model: next expected PC per instance; redirects restart it.
    logic [63:0] exp16_pc = RV;
    logic [63:0] exp64_pc = RV;

    always @(negedge clk) begin
        if (rst16) begin
            exp16_pc = RV;
        end else begin
            check("size16", size16, 2);
            check("we16", we16, 0);
            check("undef_rule16", undef16, valid16 && !fault16 && (insn16[1:0] != 2'b11));
`ifndef POLARIS_IFETCH_MISALIGN_EN
            check("fault16_tied", fault16, 0);
`endif
            if (redir16) begin
                exp16_pc = rpc16 & ~64'd1;
            end else if (valid16 && ready16) begin
                check("pop_pc16", ipc16, exp16_pc);
                check("pop_insn16", insn16, mem_word(exp16_pc));
                exp16_pc = exp16_pc + 64'd4;
            end
        end
    end

    always @(negedge clk) begin
        if (rst64) begin
            exp64_pc = RV;
        end else begin
            check("size64", size64, 2);
            check("we64", we64, 0);
            check("undef_rule64", undef64, valid64 && !fault64 && (insn64[1:0] != 2'b11));
            if (redir64) begin
                exp64_pc = rpc64 & ~64'd3;
            end else if (valid64 && ready64) begin
                check("pop_pc64", ipc64, exp64_pc);
                check("pop_insn64", insn64, mem_word(exp64_pc));
                exp64_pc = exp64_pc + 64'd4;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst16 = 1'b1; ack16 = 1'b1; redir16 = 1'b0; ready16 = 1'b0; rpc16 = '0;
        rst64 = 1'b1; ack64 = 1'b1; redir64 = 1'b0; ready64 = 1'b0; rpc64 = '0;
        tick();
        tick();

        // Reset values
        check("rst_adr", adr16, RV);
        check("rst_vpa", vpa16, 1);
        check("rst_we", we16, 0);
        check("rst_size", size16, 2);
        check("rst_valid", valid16, 0);
        check("rst_undef", undef16, 0);
        check("rst_fault", fault16, 0);

        // Two halfword beats form the first instruction
        rst16 = 1'b0;
        repeat (4) tick();
        check("first_valid", valid16, 1);
        check("first_insn", insn16, 32'h0000_0013);
        check("first_pc", ipc16, RV);
        check("first_undef", undef16, 0);
        check("first_adr", adr16, 64'hFFFF_FFFF_FFFF_FF04);

        // Queue fills: fetch parks with address held
        repeat (4) tick();
        check("full_vpa", vpa16, 0);
        check("full_adr", adr16, 64'hFFFF_FFFF_FFFF_FF08);
        repeat (2) tick();
        check("hold_vpa", vpa16, 0);
        check("hold_adr", adr16, 64'hFFFF_FFFF_FFFF_FF08);

        // One pop: fetch resumes on the following cycle
        ready16 = 1'b1;
        tick();
        ready16 = 1'b0;
        check("resume_vpa", vpa16, 1);
        check("resume_adr", adr16, 64'hFFFF_FFFF_FFFF_FF08);
        check("ones_insn", insn16, 32'hFFFF_FFFF);
        check("ones_undef", undef16, 0);

        repeat (4) tick();
        check("refill_vpa", vpa16, 0);
        check("refill_adr", adr16, 64'hFFFF_FFFF_FFFF_FF0C);
        ready16 = 1'b1;
        tick();
        ready16 = 1'b0;
        check("zero_insn", insn16, 32'h0000_0000);
        check("zero_undef", undef16, 1);

        // Redirect with a low halfword already captured
        repeat (2) tick();
        check("mid_word_adr", adr16, 64'hFFFF_FFFF_FFFF_FF0E);
        redir16 = 1'b1;
        rpc16   = 64'h1000;
        tick();
        redir16 = 1'b0;
        check("redir_valid", valid16, 0);
        check("redir_adr", adr16, 64'h1000);
        check("redir_vpa", vpa16, 1);
        ready16 = 1'b1;
        wait_valid16(20);
        check("redir_pc", ipc16, 64'h1000);
        check("redir_insn", insn16, 32'hB5C1_B5C3);
        repeat (6) tick();

        // Address wrap from the top of memory
        redir16 = 1'b1;
        rpc16   = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        redir16 = 1'b0;
        wait_valid16(20);
        check("wrap_pc_top", ipc16, 64'hFFFF_FFFF_FFFF_FFFC);
        check("wrap_insn_top", insn16, 32'h5A3D_5A3F);
        tick();
        wait_valid16(20);
        check("wrap_pc_zero", ipc16, 64'h0);
        check("wrap_insn_zero", insn16, 32'hA5C1_A5C3);
        tick();

        // Misaligned redirect target
        ready16 = 1'b0;
        redir16 = 1'b1;
        rpc16   = 64'h1002;
        tick();
        redir16 = 1'b0;
`ifdef POLARIS_IFETCH_MISALIGN_EN
        check("mis_fault", fault16, 1);
        check("mis_vpa", vpa16, 0);
        check("mis_valid", valid16, 1);
        check("mis_pc", ipc16, 64'h1002);
        check("mis_insn", insn16, 32'h0);
        repeat (3) tick();
        check("mis_parked", vpa16, 0);
`else
        check("mis_adr", adr16, 64'h1002);
        check("mis_vpa", vpa16, 1);
        check("mis_fault", fault16, 0);
        ready16 = 1'b1;
        wait_valid16(20);
        check("mis_pc", ipc16, 64'h1002);
        check("mis_insn", insn16, 32'hB5C7_B5C1);
        repeat (6) tick();
`endif

        // Reset mid-flight returns to reset values at once
        ready16 = 1'b0;
        rst16   = 1'b1;
        #1;
        check("arst_adr", adr16, RV);
        check("arst_vpa", vpa16, 1);
        check("arst_valid", valid16, 0);
        tick();

        // 64-bit bus: one beat yields two instructions
        check("rst64_adr", adr64, RV);
        rst64 = 1'b0;
        repeat (2) tick();
        check("b64_valid", valid64, 1);
        check("b64_insn0", insn64, 32'h0000_0013);
        check("b64_pc0", ipc64, RV);
        check("b64_full_vpa", vpa64, 0);
        check("b64_adr", adr64, 64'hFFFF_FFFF_FFFF_FF08);
        ready64 = 1'b1;
        tick();
        check("b64_half_vpa", vpa64, 0);
        check("b64_pc1", ipc64, 64'hFFFF_FFFF_FFFF_FF04);
        check("b64_insn1", insn64, 32'hFFFF_FFFF);
        tick();
        ready64 = 1'b0;
        check("b64_resume_vpa", vpa64, 1);
        check("b64_empty", valid64, 0);
        check("b64_resume_adr", adr64, 64'hFFFF_FFFF_FFFF_FF08);

        // Redirect with pc[2]=1: low word of the first beat is dropped
        redir64 = 1'b1;
        rpc64   = 64'h1004;
        tick();
        redir64 = 1'b0;
        check("b64_redir_adr", adr64, 64'h1000);
        check("b64_redir_valid", valid64, 0);
        repeat (2) tick();
        check("b64_drop_valid", valid64, 1);
        check("b64_drop_pc", ipc64, 64'h1004);
        check("b64_drop_insn", insn64, 32'hB5C5_B5C7);
        check("b64_drop_vpa", vpa64, 0);
        check("b64_drop_adr", adr64, 64'h1008);
        ready64 = 1'b1;
        repeat (10) tick();
        ready64 = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
